regfile_param: RTL
==================

# regfile_param

Parametrised general-purpose register file for the MIPS pipeline core: two architectural read ports, one byte-enabled write port on the rising clock edge, and an independent debug read port. A built-in clear sequencer zeroes every entry one per cycle after reset or a software clear request, and signals readiness to the pipeline. Optional write-to-read forwarding recovers the same-cycle visibility that the decode stage needs.

## Interface
- WIDTH, 32: data width in bits; multiple of 8.
- DEPTH, 32: number of registers; power of two, ≥ 2.
- AW, $clog2(DEPTH): address width (derived, do not override).
- CLK  in  1  clock; all state changes on rising edge.
- Reset_n  in  1  synchronous, active-low reset; sampled on CLK rising edge.
- Clear  in  1  software clear request; one-cycle pulse sufficient.
- WE3  in  WIDTH/8  byte write enables for port 3.
- RA1, RA2  in  AW  read addresses, ports 1/2.
- RA3  in  AW  write address.
- WD3  in  WIDTH  write data.
- RD1, RD2  out  WIDTH  read data, ports 1/2.
- RA4  in  AW  debug read address.
- RD4  out  WIDTH  debug read data.
- Ready  out  1  high when the clear sweep is complete and writes are accepted.
- WrDrop  out  1  sticky: a non-zero WE3 write to a non-zero address was discarded.

## Operation
- States: CLEAR, READY. Sweep pointer ptr, AW+1 bits.
- Reset_n low at an edge: state←CLEAR, ptr←0, WrDrop←0; no entry is written while Reset_n is held low.
- CLEAR with Reset_n high: rf[ptr]←0, ptr←ptr+1; after rf[DEPTH-1] is written, state←READY.
- READY with Clear=1: state←CLEAR, ptr←0. Clear in CLEAR is ignored; the sweep does not restart.
- Write in READY, Clear=0, RA3≠0: for each byte b with WE3[b]=1, rf[RA3][8b+7:8b]←WD3 byte b; other bytes are held.
- RA3=0: write silently ignored; register 0 is never stored; WrDrop is not affected.
- WE3≠0, RA3≠0, and (state=CLEAR or Clear=1): write discarded, WrDrop←1. WrDrop is cleared only by reset.
- Reads are combinational. Address 0 returns 0. While not Ready, RD1/RD2/RD4 return 0.
- RD4 always returns the stored value. It is never forwarded.

## Timing
- Ready=0 while Reset_n is low. Ready rises exactly DEPTH cycles after the first edge with Reset_n high.
- Software Clear: Ready falls the cycle after the Clear edge and rises DEPTH cycles later.
- Write latency: the stored value is visible on RD1/RD2/RD4 in the cycle following the write edge.
- Reset mid-sweep: ptr returns to 0 and the sweep restarts in full.
- Reset outputs: Ready=0, WrDrop=0, RD1=RD2=RD4=0.

## Configuration
- REGFILE_BYPASS_EN defined:
  - RD1/RD2 forward port 3 combinationally when Ready, RA3=RAx≠0, and Clear=0.
  - Forwarding is per byte: enabled bytes come from WD3, the rest from rf.
  - Result: a write and a read in the same cycle return the new data.
- REGFILE_BYPASS_EN undefined:
  - No forwarding. A same-cycle read returns the old value.
  - The pipeline must stall one cycle or forward externally.

## Test plan
- Reset_n low for 3 cycles, then high -> Ready=0 for 32 cycles then 1. Every RD4 sweep of addresses 0..31 returns 0. WrDrop=0.
- Ready, write RA3=5, WD3=0xDEADBEEF, WE3=4'hF; next cycle write RA3=5, WD3=0x00001122, WE3=4'b0011 -> RA1=5 reads 0xDEAD1122. Write RA3=0 -> RD1 for RA1=0 stays 0.
- Bypass defined: write RA3=7, WD3=0xA5A5A5A5, WE3=4'hF with RA1=7 in the same cycle -> RD1=0xA5A5A5A5 in that cycle while RD4 (RA4=7) shows the old value. Bypass undefined: RD1 shows the old value, then 0xA5A5A5A5 next cycle.
- Write to RA3=3 during the sweep (cycle 10 after reset) -> WrDrop=1. After Ready, rf[3]=0. WrDrop stays 1 until the next reset.
- Ready, rf[9]=0x12345678; pulse Clear together with a write to RA3=9 -> write discarded, WrDrop=1. Ready=0 for 32 cycles, then rf[9]=0.
- Reset_n pulsed low at sweep cycle 20 -> Ready remains 0 and rises exactly 32 cycles after Reset_n returns high.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised MIPS register file: 2 read ports, byte-enabled write port, debug read port,
// clear sequencer with Ready/WrDrop. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_param #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               Reset_n,
  input  logic               Clear,
  input  logic [WIDTH/8-1:0] WE3,
  input  logic [AW-1:0]      RA1,
  input  logic [AW-1:0]      RA2,
  input  logic [AW-1:0]      RA3,
  input  logic [WIDTH-1:0]   WD3,
  output logic [WIDTH-1:0]   RD1,
  output logic [WIDTH-1:0]   RD2,
  input  logic [AW-1:0]      RA4,
  output logic [WIDTH-1:0]   RD4,
  output logic               Ready,
  output logic               WrDrop
);

  localparam int NB = WIDTH / 8;
  localparam logic [AW:0] LAST = (AW + 1)'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [AW:0]      ptr_q, ptr_d;
  logic             wr_drop_q, wr_drop_d;
  logic [WIDTH-1:0] rf_q [DEPTH];

  logic             ready;
  logic             wr_req;
  logic [NB-1:0]    rf_we;
  logic [AW-1:0]    rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic [WIDTH-1:0] rd1_mux, rd2_mux;

  assign ready  = (state_q == ST_READY);
  assign wr_req = (|WE3) && (RA3 != '0);

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_q   <= ST_CLEAR;
      ptr_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_drop_d = wr_drop_q;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + (AW + 1)'(1);
        if (ptr_q == LAST) state_d = ST_READY;
      end
      ST_READY: begin
        if (Clear) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    // A real write that cannot land (sweep running or clear requested) is remembered
    if (wr_req && (state_q == ST_CLEAR || Clear)) wr_drop_d = 1'b1;
  end

  always_comb begin
    Ready    = ready;
    WrDrop   = wr_drop_q;
    rf_we    = '0;
    rf_waddr = RA3;
    rf_wdata = WD3;
    if (Reset_n) begin
      if (state_q == ST_CLEAR) begin
        rf_we    = '1;
        rf_waddr = ptr_q[AW-1:0];
        rf_wdata = '0;
      end else if (!Clear && RA3 != '0) begin
        rf_we = WE3;
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int b = 0; b < NB; b++) begin
      if (rf_we[b]) rf_q[rf_waddr][8*b +: 8] <= rf_wdata[8*b +: 8];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp1, byp2;
  assign byp1 = ready && !Clear && (RA3 == RA1) && (RA1 != '0);
  assign byp2 = ready && !Clear && (RA3 == RA2) && (RA2 != '0);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_byte
`ifdef REGFILE_BYPASS_EN
      assign rd1_mux[8*gi +: 8] = (byp1 && WE3[gi]) ? WD3[8*gi +: 8] : rf_q[RA1][8*gi +: 8];
      assign rd2_mux[8*gi +: 8] = (byp2 && WE3[gi]) ? WD3[8*gi +: 8] : rf_q[RA2][8*gi +: 8];
`else
      assign rd1_mux[8*gi +: 8] = rf_q[RA1][8*gi +: 8];
      assign rd2_mux[8*gi +: 8] = rf_q[RA2][8*gi +: 8];
`endif
    end
  endgenerate

  // Debug port always shows the stored value, never the in-flight write
  assign RD1 = (ready && RA1 != '0) ? rd1_mux : '0;
  assign RD2 = (ready && RA2 != '0) ? rd2_mux : '0;
  assign RD4 = (ready && RA4 != '0) ? rf_q[RA4] : '0;

endmodule
